// File: rtl/hpdcache_bank_xbar_q.sv
// ----------------------------------------------------------------------------
// hpdcache_bank_xbar_q
//
// Crossbar between NREQ cache requesters and NBANK cache banks.
//
// Request path: each requester names a bank through a bit field of its
// address offset. Every bank arbitrates combinationally among the requesters
// that target it, using either fixed priority (lowest index wins) or
// round-robin. The cycle after a bank accepts a request, the crossbar
// forwards that requester's 2nd-cycle abort and tag/PMA to the bank.
//
// Response path: each bank response carries a destination requester id.
// Every requester arbitrates round-robin among the banks that target it. The
// winner goes into a small per-requester first-word-fall-through FIFO.
// Responses whose id names no requester are accepted and dropped.
//
// Handshake semantics (all ports): a transfer happens on a rising clk_i edge
// where valid and ready are both 1. Ready may depend combinationally on
// valid. A response producer keeps its valid and payload stable until the
// transfer happens.
//
// Ports:
//   clk_i, rst_i          clock; synchronous active-high reset
//   core_req_*            per-requester request, offset, 2nd-cycle abort/s2
//   core_rsp_*            per-requester response (FIFO head)
//   bank_req_*            per-bank granted request and 2nd-cycle abort/s2
//   bank_rsp_*            per-bank response with destination id
// ----------------------------------------------------------------------------
module hpdcache_bank_xbar_q #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned NBANK     = 2,
    parameter int unsigned REQ_W     = 64,
    parameter int unsigned OFF_W     = 12,
    parameter int unsigned BSEL_LSB  = 3,
    parameter int unsigned S2_W      = 34,
    parameter int unsigned RSP_W     = 64,
    parameter int unsigned SID_W     = 3,
    parameter int unsigned RSP_DEPTH = 2,
    parameter int unsigned ARB_RR    = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [NREQ-1:0]         core_req_valid_i,
    output logic [NREQ-1:0]         core_req_ready_o,
    input  logic [NREQ*REQ_W-1:0]   core_req_i,
    input  logic [NREQ*OFF_W-1:0]   core_req_off_i,
    input  logic [NREQ-1:0]         core_req_abort_i,
    input  logic [NREQ*S2_W-1:0]    core_req_s2_i,
    output logic [NREQ-1:0]         core_rsp_valid_o,
    input  logic [NREQ-1:0]         core_rsp_ready_i,
    output logic [NREQ*RSP_W-1:0]   core_rsp_o,
    output logic [NBANK-1:0]        bank_req_valid_o,
    input  logic [NBANK-1:0]        bank_req_ready_i,
    output logic [NBANK*REQ_W-1:0]  bank_req_o,
    output logic [NBANK-1:0]        bank_abort_o,
    output logic [NBANK*S2_W-1:0]   bank_s2_o,
    input  logic [NBANK-1:0]        bank_rsp_valid_i,
    output logic [NBANK-1:0]        bank_rsp_ready_o,
    input  logic [NBANK*RSP_W-1:0]  bank_rsp_i,
    input  logic [NBANK*SID_W-1:0]  bank_rsp_sid_i
);

    localparam int unsigned BW  = (NBANK > 1) ? $clog2(NBANK) : 1;
    localparam int unsigned RIW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned DW  = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int unsigned CW  = $clog2(RSP_DEPTH + 1);

    // ------------------------------------------------------------------
    // Request path
    // ------------------------------------------------------------------
    logic [BW-1:0]  bid      [NREQ];
    logic [RIW-1:0] rr_ptr_q [NBANK];
    logic [NBANK-1:0] gnt_vld;
    logic [RIW-1:0] gnt_idx  [NBANK];
    logic [NBANK-1:0] bank_hs;
    logic [NBANK-1:0] s2_vld_q;
    logic [RIW-1:0] s2_idx_q [NBANK];

    for (genvar r = 0; r < NREQ; r++) begin : g_bid
        if (NBANK > 1) begin : g_multi
            assign bid[r] = core_req_off_i[r*OFF_W + BSEL_LSB +: BW];
        end else begin : g_single
            assign bid[r] = '0;
        end
    end

    // Per-bank search for the first valid requester targeting the bank,
    // starting at index 0 (fixed priority) or at the bank's pointer.
    always_comb begin : req_arb
        logic [RIW:0]   sum;
        logic [RIW-1:0] idx;
        sum = '0;
        idx = '0;
        for (int b = 0; b < NBANK; b++) begin
            gnt_vld[b] = 1'b0;
            gnt_idx[b] = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (ARB_RR != 0) begin
                    sum = {1'b0, rr_ptr_q[b]} + (RIW+1)'(i);
                    if (sum >= (RIW+1)'(NREQ)) begin
                        sum = sum - (RIW+1)'(NREQ);
                    end
                end else begin
                    sum = (RIW+1)'(i);
                end
                idx = sum[RIW-1:0];
                if (!gnt_vld[b] && core_req_valid_i[idx] && (bid[idx] == BW'(b))) begin
                    gnt_vld[b] = 1'b1;
                    gnt_idx[b] = idx;
                end
            end
        end
    end

    always_comb begin : req_out
        for (int r = 0; r < NREQ; r++) begin
            core_req_ready_o[r] = !rst_i && gnt_vld[bid[r]]
                                  && (gnt_idx[bid[r]] == RIW'(r))
                                  && bank_req_ready_i[bid[r]];
        end
        for (int b = 0; b < NBANK; b++) begin
            bank_req_valid_o[b] = gnt_vld[b] && !rst_i;
            bank_req_o[b*REQ_W +: REQ_W] = gnt_vld[b]
                ? core_req_i[32'(gnt_idx[b])*REQ_W +: REQ_W] : '0;
            bank_abort_o[b] = s2_vld_q[b] && core_req_abort_i[s2_idx_q[b]];
            bank_s2_o[b*S2_W +: S2_W] = s2_vld_q[b]
                ? core_req_s2_i[32'(s2_idx_q[b])*S2_W +: S2_W] : '0;
        end
    end

    assign bank_hs = bank_req_valid_o & bank_req_ready_i;

    // s2_vld marks the cycle right after an accepted request; a new
    // handshake on the same bank keeps it set for the next request.
    always_ff @(posedge clk_i) begin : req_state
        if (rst_i) begin
            for (int b = 0; b < NBANK; b++) begin
                rr_ptr_q[b] <= '0;
                s2_vld_q[b] <= 1'b0;
                s2_idx_q[b] <= '0;
            end
        end else begin
            for (int b = 0; b < NBANK; b++) begin
                if (bank_hs[b]) begin
                    rr_ptr_q[b] <= (gnt_idx[b] == RIW'(NREQ-1)) ? '0 : gnt_idx[b] + 1'b1;
                    s2_vld_q[b] <= 1'b1;
                    s2_idx_q[b] <= gnt_idx[b];
                end else begin
                    s2_vld_q[b] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Response path
    // ------------------------------------------------------------------
    logic [BW-1:0]    rsp_ptr_q     [NREQ];
    logic [BW-1:0]    rsp_win       [NREQ];
    logic [NREQ-1:0]  rsp_push;
    logic [NREQ-1:0]  rsp_pop;
    logic [RSP_W-1:0] rsp_push_data [NREQ];
    logic [NREQ-1:0]  fifo_full;
    logic [RSP_W-1:0] fifo_mem_q    [NREQ][RSP_DEPTH];
    logic [DW-1:0]    fifo_wptr_q   [NREQ];
    logic [DW-1:0]    fifo_rptr_q   [NREQ];
    logic [CW-1:0]    fifo_cnt_q    [NREQ];

    function automatic logic [DW-1:0] ptr_inc(input logic [DW-1:0] p);
        return (p == DW'(RSP_DEPTH-1)) ? '0 : p + 1'b1;
    endfunction

    for (genvar r = 0; r < NREQ; r++) begin : g_fifo_out
        assign fifo_full[r]                = (fifo_cnt_q[r] == CW'(RSP_DEPTH));
        assign core_rsp_valid_o[r]         = (fifo_cnt_q[r] != '0);
        assign core_rsp_o[r*RSP_W +: RSP_W] = fifo_mem_q[r][fifo_rptr_q[r]];
    end

    assign rsp_pop = core_rsp_valid_o & core_rsp_ready_i;

    // Each requester picks one bank round-robin; a bank is only released
    // when its response actually enters the FIFO. A pop in the same cycle
    // does not free a slot for a push (no bypass).
    always_comb begin : rsp_arb
        logic [BW:0]   sum;
        logic [BW-1:0] bb;
        logic          found;
        sum              = '0;
        bb               = '0;
        found            = 1'b0;
        bank_rsp_ready_o = '0;
        rsp_push         = '0;
        for (int r = 0; r < NREQ; r++) begin
            rsp_win[r]       = '0;
            rsp_push_data[r] = '0;
            found            = 1'b0;
            for (int i = 0; i < NBANK; i++) begin
                sum = {1'b0, rsp_ptr_q[r]} + (BW+1)'(i);
                if (sum >= (BW+1)'(NBANK)) begin
                    sum = sum - (BW+1)'(NBANK);
                end
                bb = sum[BW-1:0];
                if (!found && bank_rsp_valid_i[bb]
                    && (32'(bank_rsp_sid_i[32'(bb)*SID_W +: SID_W]) == r)) begin
                    found      = 1'b1;
                    rsp_win[r] = bb;
                end
            end
            if (found && !fifo_full[r]) begin
                rsp_push[r]                = 1'b1;
                bank_rsp_ready_o[rsp_win[r]] = 1'b1;
                rsp_push_data[r]           = bank_rsp_i[32'(rsp_win[r])*RSP_W +: RSP_W];
            end
        end
        // Responses addressed to no requester are swallowed.
        for (int b = 0; b < NBANK; b++) begin
            if (32'(bank_rsp_sid_i[b*SID_W +: SID_W]) >= NREQ) begin
                bank_rsp_ready_o[b] = 1'b1;
            end
        end
        if (rst_i) begin
            bank_rsp_ready_o = '0;
            rsp_push         = '0;
        end
    end

    always_ff @(posedge clk_i) begin : rsp_state
        if (rst_i) begin
            for (int r = 0; r < NREQ; r++) begin
                rsp_ptr_q[r]   <= '0;
                fifo_wptr_q[r] <= '0;
                fifo_rptr_q[r] <= '0;
                fifo_cnt_q[r]  <= '0;
            end
        end else begin
            for (int r = 0; r < NREQ; r++) begin
                if (rsp_push[r]) begin
                    fifo_wptr_q[r] <= ptr_inc(fifo_wptr_q[r]);
                    rsp_ptr_q[r]   <= (rsp_win[r] == BW'(NBANK-1)) ? '0 : rsp_win[r] + 1'b1;
                end
                if (rsp_pop[r]) begin
                    fifo_rptr_q[r] <= ptr_inc(fifo_rptr_q[r]);
                end
                if (rsp_push[r] && !rsp_pop[r]) begin
                    fifo_cnt_q[r] <= fifo_cnt_q[r] + 1'b1;
                end else if (!rsp_push[r] && rsp_pop[r]) begin
                    fifo_cnt_q[r] <= fifo_cnt_q[r] - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: only slots below the occupancy are visible.
    always_ff @(posedge clk_i) begin : rsp_mem
        for (int r = 0; r < NREQ; r++) begin
            if (rsp_push[r]) begin
                fifo_mem_q[r][fifo_wptr_q[r]] <= rsp_push_data[r];
            end
        end
    end

endmodule

// File: doc/hpdcache_bank_xbar_q.md
HPDCACHE_BANK_XBAR_Q -- requirements
Module: hpdcache_bank_xbar_q

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters (1..16).
REQ-002 SHALL have parameter NBANK, default 2: number of banks, a power of 2 (1..8).
REQ-003 SHALL have parameter REQ_W, default 64: width of the 1st-cycle request payload.
REQ-004 SHALL have parameter OFF_W, default 12: width of the request address offset.
REQ-005 SHALL have parameter BSEL_LSB, default 3: lowest offset bit of the bank-select field.
REQ-006 SHALL have parameter S2_W, default 34: width of the 2nd-cycle payload (tag plus PMA).
REQ-007 SHALL have parameter RSP_W, default 64: width of the response payload.
REQ-008 SHALL have parameter SID_W, default 3: width of the response source ID.
REQ-009 SHALL have parameter RSP_DEPTH, default 2: per-requester response FIFO depth (>=1).
REQ-010 SHALL have parameter ARB_RR, default 1: 1 = round-robin request arbitration, 0 = fixed priority.
REQ-011 SHALL have clk_i  in  1  sole clock; all state updates on its rising edge.
REQ-012 SHALL have rst_i  in  1  reset, synchronous and active-high.
REQ-013 SHALL have core_req_valid_i  in  NREQ  per-requester request valid.
REQ-014 SHALL have core_req_ready_o  out  NREQ  per-requester request accepted.
REQ-015 SHALL have core_req_i  in  NREQ*REQ_W  request payloads, one slice per requester.
REQ-016 SHALL have core_req_off_i  in  NREQ*OFF_W  request address offsets.
REQ-017 SHALL have core_req_abort_i  in  NREQ  2nd-cycle abort.
REQ-018 SHALL have core_req_s2_i  in  NREQ*S2_W  2nd-cycle tag/PMA.
REQ-019 SHALL have core_rsp_valid_o  out  NREQ  response valid.
REQ-020 SHALL have core_rsp_ready_i  in  NREQ  response ready.
REQ-021 SHALL have core_rsp_o  out  NREQ*RSP_W  response payloads.
REQ-022 SHALL have bank_req_valid_o  out  NBANK  request valid to each bank.
REQ-023 SHALL have bank_req_ready_i  in  NBANK  bank accepts request.
REQ-024 SHALL have bank_req_o  out  NBANK*REQ_W  granted request payload.
REQ-025 SHALL have bank_abort_o  out  NBANK  2nd-cycle abort of the previously accepted request.
REQ-026 SHALL have bank_s2_o  out  NBANK*S2_W  2nd-cycle tag/PMA of the previously accepted request.
REQ-027 SHALL have bank_rsp_valid_i / bank_rsp_ready_o  in/out  NBANK each  bank response handshake.
REQ-028 SHALL have bank_rsp_i  in  NBANK*RSP_W and bank_rsp_sid_i  in  NBANK*SID_W  bank response payload and destination requester.

Function
REQ-029 SHALL route requester r to bank bid(r) = core_req_off_i[r][BSEL_LSB +: log2(NBANK)]; bid = 0 when NBANK = 1.
REQ-030 SHALL arbitrate each bank combinationally among requesters targeting it; ARB_RR=0: lowest index wins; ARB_RR=1: first valid at or after the bank's pointer wins.
REQ-031 SHALL advance a bank's RR pointer to (winner+1) mod NREQ only on bank handshake (valid & ready); no handshake -> pointer holds.
REQ-032 SHALL drive bank_req_valid_o[b] = any grant to b, bank_req_o[b] = winner's payload (all zero when no grant), core_req_ready_o[r] = grant(r) & bank_req_ready_i[bid(r)].
REQ-033 SHALL, on bank handshake, register winner index and a per-bank s2_vld flag; next cycle bank_abort_o[b] = s2_vld & core_req_abort_i[winner], bank_s2_o[b] = winner's core_req_s2_i; both zero when s2_vld = 0.
REQ-034 SHALL clear s2_vld one cycle after it was set unless a new handshake occurs on that bank in the same cycle (back-to-back accepted).
REQ-035 SHALL steer each bank response to requester sid; sid >= NREQ SHALL be accepted (bank_rsp_ready_o = 1) and discarded.
REQ-036 SHALL arbitrate, per requester, round-robin among banks whose response targets it; winner pushed into that requester's FIFO; bank_rsp_ready_o[b] = 1 only if b wins and the FIFO is not full (no same-cycle pop bypass).
REQ-037 SHALL present FIFO head first-word-fall-through: core_rsp_valid_o = FIFO not empty; pop on valid & core_rsp_ready_i; bank-to-core latency exactly 1 cycle.
REQ-038 SHALL handle FIFO pointer wrap modulo RSP_DEPTH; simultaneous push and pop when non-empty keeps occupancy unchanged.
REQ-039 SHALL preserve per-bank response order per requester; no ordering across banks is guaranteed.

Reset
REQ-040 SHALL, while rst_i = 1 at a clock edge: empty all FIFOs, set all RR pointers to 0, clear all s2_vld; core_rsp_valid_o, bank_abort_o, bank_s2_o = 0 the cycle after; a request in flight is lost.
REQ-041 SHALL force core_req_ready_o, bank_req_valid_o, bank_rsp_ready_o to 0 while rst_i = 1.

Verification
REQ-042 SHALL cover: NREQ=4, NBANK=2, req0/req2 both to bank0, ready=1 for 4 cycles, ARB_RR=1 -> grants 0,2,0,2; ARB_RR=0 -> 0,0,0,0.
REQ-043 SHALL cover: req1 accepted by bank1 cycle N, abort1=1 and s2=0x2A cycle N+1 -> bank_abort_o[1]=1, bank_s2_o[1]=0x2A cycle N+1 only.
REQ-044 SHALL cover: both banks respond sid=3 same cycle, core_rsp_ready_i[3]=1 -> both delivered on consecutive cycles, bank0 first after reset.
REQ-045 SHALL cover: RSP_DEPTH=2, core_rsp_ready_i[0]=0, 3 responses sid=0 -> third stalls (bank_rsp_ready_o=0) until one pop.
REQ-046 SHALL cover: sid=7 with NREQ=4 -> response accepted, no core_rsp_valid_o.
REQ-047 SHALL cover: rst_i=1 with full FIFO and s2_vld=1 -> next cycle core_rsp_valid_o=0, bank_abort_o=0, RR pointers 0.
